// File: rtl/sensor_readout_scanner.sv
// rtl/sensor_readout_scanner.sv - multi-channel sensor latch, display scanner and BCD converter
//
// Latches per-channel binary readings, picks one channel for display (dwell-timer
// rotation or manual select) and converts it to 3-digit BCD for a 4-digit FND driver.
//
// Ports:
//    clk          system clock, rising edge
//    reset_n      synchronous reset, active low
//    in_valid     reading write strobe
//    in_ch        channel index of the write (out-of-range indexes are dropped)
//    in_data      binary reading
//    auto_mode    1 = rotate on dwell timer, 0 = follow sel_ch
//    sel_ch       manual display channel (out-of-range indexes are dropped)
//    hold         freeze selection, dwell timer and conversion start
//    value        {channel, hundreds, tens, ones}
//    value_valid  first conversion has completed
//    overflow     displayed reading was saturated to 999
//    busy         conversion engine active
module sensor_readout_scanner #(
   parameter int CH_NUM    = 4,
   parameter int DATA_W    = 8,
   parameter int DWELL_CYC = 125_000_000,
   localparam int CH_W     = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic              auto_mode,
   input  logic [CH_W-1:0]   sel_ch,
   input  logic              hold,
   output logic [15:0]       value,
   output logic              value_valid,
   output logic              overflow,
   output logic              busy
);

   localparam int NSLOT = 1 << CH_W;
   localparam int DW_W  = $clog2(DWELL_CYC);
   localparam int BC_W  = $clog2(DATA_W);

   // One bit per encodable channel index: set where the index names a real channel.
   localparam logic [NSLOT-1:0] CH_MASK    = {NSLOT{1'b1}} >> (NSLOT - CH_NUM);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CH_NUM - 1);
   localparam logic [BC_W-1:0]  BIT_LAST   = BC_W'(DATA_W - 1);
   localparam logic [10:0]      SAT_MAX    = 11'd999;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   ch_reg_q [CH_NUM];
   logic [DATA_W-1:0]   ch_reg_d [CH_NUM];
   logic [CH_W-1:0]     disp_ch_q, disp_ch_d;
   logic [DW_W-1:0]     dwell_cnt_q, dwell_cnt_d;
   logic                pending_q, pending_d;
   logic                first_q, first_d;
   logic [DATA_W-1:0]   snap_q, snap_d;
   logic [CH_W-1:0]     snap_ch_q, snap_ch_d;
   logic                sat_q, sat_d;
   logic [11:0]         bcd_q, bcd_d;
   logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [15:0]         value_q, value_d;
   logic                value_valid_q, value_valid_d;
   logic                overflow_q, overflow_d;

   logic                wr_ok;
   logic                trig;
   logic [10:0]         raw_ext;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign wr_ok   = in_valid && CH_MASK[in_ch];
   assign raw_ext = 11'(ch_reg_q[disp_ch_q]);

   always_comb begin
      state_d       = state_q;
      ch_reg_d      = ch_reg_q;
      disp_ch_d     = disp_ch_q;
      dwell_cnt_d   = dwell_cnt_q;
      first_d       = 1'b0;
      snap_d        = snap_q;
      snap_ch_d     = snap_ch_q;
      sat_d         = sat_q;
      bcd_d         = bcd_q;
      bit_cnt_d     = bit_cnt_q;
      value_d       = value_q;
      value_valid_d = value_valid_q;
      overflow_d    = overflow_q;

      for (int i = 0; i < CH_NUM; i++) begin
         if (wr_ok && in_ch == CH_W'(i)) begin
            ch_reg_d[i] = in_data;
         end
      end

      if (!hold) begin
         if (auto_mode) begin
            if (dwell_cnt_q == DWELL_LAST) begin
               dwell_cnt_d = '0;
               disp_ch_d   = (disp_ch_q == CH_LAST) ? '0 : disp_ch_q + 1'b1;
            end else begin
               dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
         end else begin
            dwell_cnt_d = '0;
            if (CH_MASK[sel_ch]) begin
               disp_ch_d = sel_ch;
            end
         end
      end

      // Every trigger is first registered into pending; the engine only ever
      // starts from pending, so simultaneous triggers collapse into one run.
      trig      = first_q || (disp_ch_d != disp_ch_q) || (wr_ok && in_ch == disp_ch_q);
      pending_d = pending_q || trig;

      case (state_q)
         S_IDLE: begin
            if (pending_q && !hold) begin
               state_d   = S_LOAD;
               pending_d = trig;
            end
         end
         S_LOAD: begin
            snap_ch_d = disp_ch_q;
            if (raw_ext > SAT_MAX) begin
               snap_d = SAT_MAX[DATA_W-1:0];
               sat_d  = 1'b1;
            end else begin
               snap_d = ch_reg_q[disp_ch_q];
               sat_d  = 1'b0;
            end
            bcd_d     = '0;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            // Input is at most 999, so the hundreds nibble never reaches 5
            // before its final shift and needs no correction.
            bcd_d     = {bcd_q[10:8], add3(bcd_q[7:4]), add3(bcd_q[3:0]), snap_q[DATA_W-1]};
            snap_d    = {snap_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            value_d       = {4'(snap_ch_q), bcd_q};
            value_valid_d = 1'b1;
            overflow_d    = sat_q;
            if (pending_q && !hold) begin
               state_d   = S_LOAD;
               pending_d = trig;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         ch_reg_q      <= '{default: '0};
         disp_ch_q     <= '0;
         dwell_cnt_q   <= '0;
         pending_q     <= 1'b0;
         first_q       <= 1'b1;
         snap_q        <= '0;
         snap_ch_q     <= '0;
         sat_q         <= 1'b0;
         bcd_q         <= '0;
         bit_cnt_q     <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_reg_q      <= ch_reg_d;
         disp_ch_q     <= disp_ch_d;
         dwell_cnt_q   <= dwell_cnt_d;
         pending_q     <= pending_d;
         first_q       <= first_d;
         snap_q        <= snap_d;
         snap_ch_q     <= snap_ch_d;
         sat_q         <= sat_d;
         bcd_q         <= bcd_d;
         bit_cnt_q     <= bit_cnt_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         overflow_q    <= overflow_d;
      end
   end

   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/sensor_readout_scanner.md
Name: sensor_readout_scanner

Overview:
- Multi-channel successor to the single-sensor humidity/temperature readout path.
- Latches up to CH_NUM binary sensor readings written through a valid strobe, in any channel order.
- Selects one channel for display, either by auto-rotation on a dwell timer or by manual select.
- Converts the selected reading to 3-digit BCD with a sequential shift-add-3 engine and presents a 16-bit word for the existing 4-digit FND controller: channel digit plus hundreds, tens and ones.

Parameters:
- CH_NUM, 4: number of input channels; legal range 2..16.
- DATA_W, 8: reading width in bits; legal range 4..10.
- DWELL_CYC, 125_000_000: clocks each channel is shown in auto mode (1 s at 125 MHz); minimum 2.
- CH_W, derived: max(1, $clog2(CH_NUM)); not user-set.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_valid  in  1  write strobe; one reading per cycle.
- in_ch  in  CH_W  channel index for the write.
- in_data  in  DATA_W  binary reading.
- auto_mode  in  1  1 = rotate channels on the dwell timer; 0 = manual select.
- sel_ch  in  CH_W  manual display channel.
- hold  in  1  freeze display selection, dwell timer and conversion start.
- value  out  16  {ch_idx[3:0], bcd_hundreds, bcd_tens, bcd_ones}.
- value_valid  out  1  high once the first conversion has completed.
- overflow  out  1  displayed reading was above 999 and has been saturated.
- busy  out  1  conversion engine not in IDLE.

Behaviour:
- Reset (reset_n low at a clk edge):
  - ch_reg[] = 0, disp_ch = 0, dwell_cnt = 0, FSM = IDLE, pending = 0.
  - value = 16'h0000, value_valid = 0, overflow = 0, busy = 0.
  - Reset mid-conversion aborts the conversion; no partial value is ever output.
- First conversion: the first cycle with reset_n high raises an internal trigger, which converts ch0.
- Writes:
  - in_valid with in_ch < CH_NUM writes in_data to ch_reg[in_ch] at that edge.
  - in_ch >= CH_NUM is ignored.
  - Writes are accepted regardless of hold, busy or mode.
- Auto mode, hold = 0:
  - dwell_cnt counts 0..DWELL_CYC-1.
  - At terminal count: dwell_cnt goes to 0 and disp_ch increments, wrapping CH_NUM-1 -> 0.
- Manual mode, hold = 0:
  - dwell_cnt is held at 0.
  - disp_ch loads sel_ch each cycle when sel_ch < CH_NUM; otherwise disp_ch keeps its value.
- Returning to auto mode: rotation resumes from the current disp_ch with dwell_cnt = 0.
- Hold = 1:
  - disp_ch and dwell_cnt are frozen and no new conversion starts.
  - A conversion already running completes normally.
  - Triggers raised while hold = 1 set pending; pending is serviced when hold falls.
- Triggers:
  - A disp_ch change.
  - A write to ch_reg[disp_ch].
  - The post-reset trigger.
- Conversion FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - IDLE: on trigger or pending with hold = 0, go to LOAD and clear pending.
  - LOAD: snapshot snap_ch = disp_ch and snap = ch_reg[disp_ch]. If snap > 999, load 999 and set sat = 1; else sat = 0. Clear the 12-bit BCD accumulator.
  - SHIFT: exactly DATA_W cycles, MSB first. Each cycle, add 3 to every BCD nibble >= 5, then shift left by one and bring in the next data bit.
  - DONE: register value = {snap_ch zero-extended to 4 bits, bcd}, value_valid = 1, overflow = sat. Then go to LOAD if pending else IDLE, clearing pending.
- Triggers during LOAD, SHIFT or DONE set pending. Multiple triggers collapse to one re-conversion, which uses the latest disp_ch and register contents.
- Latency: with FSM in IDLE, value updates DATA_W+3 clock edges after the edge that registered the trigger.
- busy = 1 in LOAD, SHIFT and DONE.
- value is stable between DONE updates and never glitches during SHIFT.

Test Plan:
- Reset, then release with CH_NUM=4, DATA_W=8, DWELL_CYC=20, auto_mode=0, sel_ch=0 -> busy rises; value = 16'h0000 and value_valid = 1 exactly 11 edges after the trigger; overflow = 0.
- Manual mode: write ch2 = 8'd173, then set sel_ch = 2 -> value = 16'h2173 11 clocks after disp_ch changes; a write of ch2 = 8'd9 during SHIFT -> pending re-conversion gives value = 16'h2009 with no intermediate value.
- Auto mode with ch0..3 = 5, 42, 199, 255 -> value cycles 0005, 1042, 2199, 3255, then back to 0005; each value change is 20 clocks apart; wrap from ch3 to ch0 is verified.
- Saturation with DATA_W=10: write ch1 = 10'd1023 and display it -> value = 16'h1999 and overflow = 1; then write ch1 = 10'd998 -> value = 16'h1998 and overflow = 0.
- Hold: assert hold in auto mode for 100 clocks while writing the displayed channel -> disp_ch and value are frozen; deassert hold -> one conversion starts on the next edge and rotation resumes.
- Corner cases:
  - in_ch = 5 with CH_NUM=4, or sel_ch out of range -> ignored, no register or display change.
  - reset_n pulsed low mid-SHIFT -> all outputs read 0 on the next edge.
  - Simultaneous writes to the displayed channel and a channel change -> a single conversion of the new channel.
